jk_count_sequencer: RTL and testbench

- Controller that sequences a WIDTH-bit register built from JK flip-flop cells: computes per-bit J/K excitations so the register counts up or down from its present value to a requested limit.
- Start/busy/done handshake with abort; exposes excitations for waveform inspection.
- Sits above the JK flip-flop cells in the practical-activity designs as their sequencing/configuration layer.

---
 rtl/jk_count_sequencer.sv | 114 +++++++++++
 tb/tb_jk_count_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_count_sequencer.sv
// jk_count_sequencer: sequences a WIDTH-bit register of JK cells so it counts
// up or down from its present value to a latched limit, with a start/busy/done
// handshake and abort. The J/K excitations are exported for inspection.
// Optional parallel load (inputs load/din) is enabled by defining PARALLEL_LOAD_EN.
module jk_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             abort,
`ifdef PARALLEL_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [WIDTH-1:0] limitReg;
  logic             dirReg;
  logic [WIDTH-1:0] toggleUp;
  logic [WIDTH-1:0] toggleDown;
  logic [WIDTH-1:0] qNext;

  // Toggle masks: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    toggleUp      = '0;
    toggleDown    = '0;
    toggleUp[0]   = 1'b1;
    toggleDown[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggleUp[i]   = toggleUp[i-1] & q[i-1];
      toggleDown[i] = toggleDown[i-1] & ~q[i-1];
    end
  end

  // Excitations: only a non-aborted run (or an idle load) drives the cells.
  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state == RUN && !abort) begin
      j_out = dirReg ? toggleUp : toggleDown;
      k_out = dirReg ? toggleUp : toggleDown;
    end
`ifdef PARALLEL_LOAD_EN
    else if (state == IDLE && load) begin
      j_out = din;
      k_out = ~din;
    end
`endif
  end

  // JK characteristic equation gives the register value after the next edge.
  always_comb begin
    qNext = (j_out & ~q) | (~k_out & q);
  end

  // Next-state logic; the run ends on the edge that makes q reach the limit.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
`ifdef PARALLEL_LOAD_EN
        if (load) stateNext = IDLE;
        else
`endif
        if (start) stateNext = (limit == q) ? DONE : RUN;
      end
      RUN: begin
        if (abort)                 stateNext = IDLE;
        else if (qNext == limitReg) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State, JK register and run parameters; start latches limit/dir only in IDLE.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      q        <= '0;
      limitReg <= '0;
      dirReg   <= 1'b1;
    end else begin
      state <= stateNext;
      q     <= qNext;
`ifdef PARALLEL_LOAD_EN
      if (state == IDLE && start && !load) begin
`else
      if (state == IDLE && start) begin
`endif
        limitReg <= limit;
        dirReg   <= dir;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed self-checking bench for jk_count_sequencer (WIDTH=4).
// The parallel-load steps are compiled only when PARALLEL_LOAD_EN is defined.
module tb_jk_count_sequencer;

  logic       clk;
  logic       clear;
  logic       start;
  logic       dir;
  logic [3:0] limit;
  logic       abort;
  logic [3:0] q;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic       busy;
  logic       done;
`ifdef PARALLEL_LOAD_EN
  logic       load;
  logic [3:0] din;
`endif

  int errors = 0;
  int checks = 0;

  jk_count_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .dir   (dir),
    .limit (limit),
    .abort (abort),
`ifdef PARALLEL_LOAD_EN
    .load  (load),
    .din   (din),
`endif
    .q     (q),
    .j_out (j_out),
    .k_out (k_out),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge with the given direction and limit.
  task automatic applyStimulus(input logic d, input logic [3:0] lim);
    start = 1'b1;
    dir   = d;
    limit = lim;
    tick();
    start = 1'b0;
  endtask

  // Step until done appears or the cycle budget runs out.
  task automatic waitDone(input string tag, input int maxCycles);
    logic seen;
    seen = done;
    for (int n = 0; n < maxCycles && !seen; n++) begin
      tick();
      seen = done;
    end
    checkOutput(tag, {15'd0, seen}, 16'd1);
    tick();
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    dir   = 1'b1;
    limit = 4'd0;
    abort = 1'b0;
`ifdef PARALLEL_LOAD_EN
    load  = 1'b0;
    din   = 4'd0;
`endif
    #3;
    checkOutput("reset_q", {12'd0, q}, 16'h0);
    checkOutput("reset_busy", {15'd0, busy}, 16'h0);
    checkOutput("reset_done", {15'd0, done}, 16'h0);
    checkOutput("reset_j", {12'd0, j_out}, 16'h0);
    checkOutput("reset_k", {12'd0, k_out}, 16'h0);
    tick();
    clear = 1'b0;
    tick();

    // Up run 0 -> 5
    applyStimulus(1'b1, 4'd5);
    checkOutput("up_busy0", {15'd0, busy}, 16'h1);
    checkOutput("up_q0", {12'd0, q}, 16'h0);
    checkOutput("up_j0", {12'd0, j_out}, 16'h1);
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) begin
        checkOutput("up_j_at3", {12'd0, j_out}, 16'h7);
        checkOutput("up_k_at3", {12'd0, k_out}, 16'h7);
      end
      tick();
      checkOutput("up_q", {12'd0, q}, 16'(k));
      checkOutput("up_busy", {15'd0, busy}, (k < 5) ? 16'h1 : 16'h0);
      checkOutput("up_done", {15'd0, done}, (k == 5) ? 16'h1 : 16'h0);
    end
    tick();
    checkOutput("up_after_done", {15'd0, done}, 16'h0);
    checkOutput("up_after_q", {12'd0, q}, 16'h5);

    // Down run 5 -> 1, then down wrap 1 -> E
    applyStimulus(1'b0, 4'd1);
    waitDone("down_to1_done", 8);
    checkOutput("down_to1_q", {12'd0, q}, 16'h1);
    applyStimulus(1'b0, 4'hE);
    checkOutput("wrap_busy", {15'd0, busy}, 16'h1);
    checkOutput("wrap_j_at1", {12'd0, j_out}, 16'h1);
    tick();
    checkOutput("wrap_q0", {12'd0, q}, 16'h0);
    checkOutput("wrap_j_at0", {12'd0, j_out}, 16'hF);
    checkOutput("wrap_k_at0", {12'd0, k_out}, 16'hF);
    tick();
    checkOutput("wrap_qF", {12'd0, q}, 16'hF);
    checkOutput("wrap_busyF", {15'd0, busy}, 16'h1);
    tick();
    checkOutput("wrap_qE", {12'd0, q}, 16'hE);
    checkOutput("wrap_done", {15'd0, done}, 16'h1);
    tick();
    checkOutput("wrap_idle", {15'd0, done | busy}, 16'h0);

    // Up wrap E -> 3, then zero-length start at 3
    applyStimulus(1'b1, 4'd3);
    waitDone("upwrap_done", 10);
    checkOutput("upwrap_q", {12'd0, q}, 16'h3);
    applyStimulus(1'b1, 4'd3);
    checkOutput("zero_done", {15'd0, done}, 16'h1);
    checkOutput("zero_busy", {15'd0, busy}, 16'h0);
    checkOutput("zero_q", {12'd0, q}, 16'h3);
    tick();
    checkOutput("zero_after", {15'd0, done}, 16'h0);

    // Start held high during a run and in DONE must be ignored
    applyStimulus(1'b1, 4'd6);
    start = 1'b1;
    dir   = 1'b0;
    limit = 4'd0;
    tick();
    checkOutput("ign_q4", {12'd0, q}, 16'h4);
    tick();
    checkOutput("ign_q5", {12'd0, q}, 16'h5);
    tick();
    checkOutput("ign_q6", {12'd0, q}, 16'h6);
    checkOutput("ign_done", {15'd0, done}, 16'h1);
    start = 1'b0;
    tick();
    checkOutput("ign_idle_q", {12'd0, q}, 16'h6);

    // Asynchronous clear mid-run, away from any clock edge
    applyStimulus(1'b1, 4'd7);
    waitDone("to7_done", 4);
    applyStimulus(1'b1, 4'd9);
    checkOutput("pre_clear_q", {12'd0, q}, 16'h7);
    #2;
    clear = 1'b1;
    #1;
    checkOutput("clear_q", {12'd0, q}, 16'h0);
    checkOutput("clear_busy", {15'd0, busy}, 16'h0);
    checkOutput("clear_done", {15'd0, done}, 16'h0);
    tick();
    clear = 1'b0;
    tick();
    checkOutput("clear_hold_q", {12'd0, q}, 16'h0);

    // Abort an up run 0 -> 9 at q=4
    applyStimulus(1'b1, 4'd9);
    for (int k = 1; k <= 4; k++) tick();
    checkOutput("abort_q4", {12'd0, q}, 16'h4);
    abort = 1'b1;
    #1;
    checkOutput("abort_j", {12'd0, j_out}, 16'h0);
    checkOutput("abort_k", {12'd0, k_out}, 16'h0);
    tick();
    abort = 1'b0;
    checkOutput("abort_hold_q", {12'd0, q}, 16'h4);
    checkOutput("abort_busy", {15'd0, busy}, 16'h0);
    checkOutput("abort_done", {15'd0, done}, 16'h0);
    tick();
    checkOutput("abort_idle_q", {12'd0, q}, 16'h4);
    checkOutput("abort_idle_done", {15'd0, done}, 16'h0);

`ifdef PARALLEL_LOAD_EN
    // Parallel load of A, then up run to C
    load = 1'b1;
    din  = 4'hA;
    #1;
    checkOutput("load_j", {12'd0, j_out}, 16'hA);
    checkOutput("load_k", {12'd0, k_out}, 16'h5);
    tick();
    load = 1'b0;
    checkOutput("load_q", {12'd0, q}, 16'hA);
    checkOutput("load_busy", {15'd0, busy}, 16'h0);
    applyStimulus(1'b1, 4'hC);
    tick();
    checkOutput("load_run_qB", {12'd0, q}, 16'hB);
    tick();
    checkOutput("load_run_qC", {12'd0, q}, 16'hC);
    checkOutput("load_run_done", {15'd0, done}, 16'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
